// File: rtl/nco_tune_if.sv
// nco_tune_if: UART byte link and NCO tuning outputs of nco_tune_ctrl
interface nco_tune_if;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        tx_active;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic [63:0] phase_inc;
  logic        inc_valid;
  logic        step_sel;
  logic        busy;
  logic        err;
  modport master (input rx_dv, rx_byte, tx_active, output tx_dv, tx_byte, phase_inc, inc_valid, step_sel, busy, err);
  modport slave (output rx_dv, rx_byte, tx_active, input tx_dv, tx_byte, phase_inc, inc_valid, step_sel, busy, err);
endinterface

// File: rtl/nco_tune_ctrl.sv
// nco_tune_ctrl: UART command parser driving the NCO phase increment
module nco_tune_ctrl #(
  parameter logic [63:0] INIT_INC     = 64'h104376A9DD10437,
  parameter logic [63:0] STEP_FINE    = 64'h7B5CA45266E2,
  parameter logic [63:0] STEP_COARSE  = 64'h45641C6E59DF0,
  parameter logic [63:0] PRESET0      = 64'h1B1B1B1B1B1B1B1,
  parameter logic [63:0] PRESET1      = 64'h104376A9DD10437,
  parameter logic [63:0] PRESET2      = 64'h28EE0CC5170287A,
  parameter logic [63:0] PRESET3      = 64'h19C0268CF359C02,
  parameter logic [63:0] MIN_INC      = 64'h0,
  parameter logic [63:0] MAX_INC      = 64'h3C3C3C3C3C3C3C3,
  parameter int unsigned TIMEOUT_CLKS = 1360000
) (
  input logic        clk,
  input logic        rst_n,
  nco_tune_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [7:0] ACK = 8'h41, NAK = 8'h45;
  typedef enum logic [2:0] {IDLE, LOAD, PIDX, APPLY, QUERY} state_t;
  state_t state, state_d;
  logic [55:0] stage, stage_d;
  logic [63:0] inc_q, inc_d, q_data, step, full, preset;
  logic [64:0] sum, lim;
  logic [2:0] cnt;
  logic [3:0] q_cnt;
  logic [TW-1:0] to_cnt;
  logic [1:0] tx_hist;
  logic [7:0] ack_byte, ack_val, tx_byte_q;
  logic ack_full, ack_set, err_d, err_q, inc_we, pulse_d, pulse_q, tog, step_q, tx_dv_q;
  logic in_range, tx_ok, send_ack, send_q, timeout;
  assign step = step_q ? STEP_COARSE : STEP_FINE;
  assign full = {stage, bus.rx_byte};
  assign sum = {1'b0, inc_q} + {1'b0, step};
  assign lim = {1'b0, MIN_INC} + {1'b0, step};
  // a value below MIN_INC wraps to a huge difference, so one compare covers both bounds
  assign in_range = ({1'b0, full} - {1'b0, MIN_INC}) <= {1'b0, MAX_INC - MIN_INC};
  assign preset = bus.rx_byte[1] ? (bus.rx_byte[0] ? PRESET3 : PRESET2) : (bus.rx_byte[0] ? PRESET1 : PRESET0);
  assign tx_ok = !bus.tx_active && tx_hist == 2'b00;
  assign send_ack = tx_ok && ack_full;
  assign send_q = tx_ok && !ack_full && state == QUERY && q_cnt != 4'd8;
  assign timeout = to_cnt == TW'(TIMEOUT_CLKS);
  always_comb begin
    state_d = state;
    stage_d = stage;
    inc_d = inc_q;
    inc_we = 1'b0;
    pulse_d = 1'b0;
    ack_set = 1'b0;
    ack_val = ACK;
    err_d = 1'b0;
    tog = 1'b0;
    case (state)
      IDLE: if (bus.rx_dv) case (bus.rx_byte)
        8'h46: state_d = LOAD;
        8'h50: state_d = PIDX;
        8'h51: state_d = QUERY;
        8'h53: begin tog = 1'b1; ack_set = 1'b1; end
        8'h2B: begin
          inc_d = sum > {1'b0, MAX_INC} ? MAX_INC : sum[63:0];
          inc_we = 1'b1;
          pulse_d = inc_d != inc_q;
          ack_set = 1'b1;
        end
        8'h2D: begin
          inc_d = {1'b0, inc_q} < lim ? MIN_INC : inc_q - step;
          inc_we = 1'b1;
          pulse_d = inc_d != inc_q;
          ack_set = 1'b1;
        end
        default: begin ack_set = 1'b1; ack_val = NAK; err_d = 1'b1; end
      endcase
      LOAD: if (bus.rx_dv) begin
        stage_d = full[55:0];
        if (cnt == 3'd7) begin
          state_d = APPLY;
          ack_set = 1'b1;
          inc_d = full;
          inc_we = in_range;
          pulse_d = in_range;
          ack_val = in_range ? ACK : NAK;
          err_d = !in_range;
        end
      end else if (timeout) begin
        state_d = IDLE;
        stage_d = '0;
        ack_set = 1'b1;
        ack_val = NAK;
        err_d = 1'b1;
      end
      PIDX: if (bus.rx_dv) begin
        state_d = APPLY;
        ack_set = 1'b1;
        inc_d = preset;
        inc_we = bus.rx_byte[7:2] == 6'd0;
        pulse_d = inc_we;
        ack_val = inc_we ? ACK : NAK;
        err_d = !inc_we;
      end else if (timeout) begin
        state_d = IDLE;
        ack_set = 1'b1;
        ack_val = NAK;
        err_d = 1'b1;
      end
      APPLY: begin state_d = IDLE; err_d = bus.rx_dv; end
      QUERY: begin
        err_d = bus.rx_dv;
        if (q_cnt == 4'd8) begin state_d = IDLE; ack_set = 1'b1; end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      stage <= '0;
      inc_q <= INIT_INC;
      step_q <= 1'b0;
      pulse_q <= 1'b0;
      err_q <= 1'b0;
      cnt <= '0;
      to_cnt <= '0;
      q_data <= '0;
      q_cnt <= '0;
      ack_full <= 1'b0;
      ack_byte <= '0;
      tx_dv_q <= 1'b0;
      tx_byte_q <= '0;
      tx_hist <= '0;
    end else begin
      state <= state_d;
      stage <= stage_d;
      inc_q <= inc_we ? inc_d : inc_q;
      step_q <= step_q ^ tog;
      pulse_q <= pulse_d;
      err_q <= err_d;
      cnt <= state == LOAD ? cnt + 3'(bus.rx_dv) : '0;
      to_cnt <= (state == LOAD || state == PIDX) && !bus.rx_dv && state_d == state ? to_cnt + TW'(1) : '0;
      q_data <= state == IDLE && state_d == QUERY ? inc_q : send_q ? q_data << 8 : q_data;
      q_cnt <= state == IDLE ? 4'd0 : q_cnt + 4'(send_q);
      ack_full <= ack_set || (ack_full && !send_ack);
      ack_byte <= ack_set ? ack_val : ack_byte;
      tx_dv_q <= send_ack || send_q;
      tx_byte_q <= send_ack ? ack_byte : send_q ? q_data[63:56] : tx_byte_q;
      tx_hist <= {tx_hist[0], send_ack || send_q};
    end
  assign bus.phase_inc = inc_q;
  assign bus.inc_valid = pulse_q;
  assign bus.step_sel = step_q;
  assign bus.err = err_q;
  assign bus.tx_dv = tx_dv_q;
  assign bus.tx_byte = tx_byte_q;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_nco_tune_ctrl.sv
// tb_nco_tune_ctrl: directed command vectors against hand-computed increments and ack bytes
module tb_nco_tune_ctrl;
  localparam int TO = 40, TXC = 20;
  localparam logic [63:0] INIT = 64'h104376A9DD10437, MAXI = 64'h3C3C3C3C3C3C3C3;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, errors = 0, iv_cnt = 0, err_cnt = 0, tx_left = 0, e0;
  logic [7:0] txq[$];
  logic [63:0] qv = 64'h0104376A9DD10437;
  nco_tune_if bus();
  nco_tune_ctrl #(.TIMEOUT_CLKS(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) tx_left <= bus.tx_dv ? TXC : (tx_left > 0 ? tx_left - 1 : 0);
  assign bus.tx_active = tx_left != 0;
  always @(negedge clk) if (rst_n) begin
    if (bus.tx_dv) txq.push_back(bus.tx_byte);
    if (bus.inc_valid) iv_cnt++;
    if (bus.err) err_cnt++;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_dv = 1'b1;
    bus.rx_byte = b;
    @(negedge clk);
    bus.rx_dv = 1'b0;
  endtask
  task automatic load(input logic [63:0] v);
    send(8'h46);
    for (int i = 7; i >= 0; i--) send(v[i*8 +: 8]);
  endtask
  task automatic expect_tx(input string tag, input logic [7:0] exp);
    logic [63:0] b;
    int n;
    n = 0;
    while (txq.size() == 0 && n < 400) begin @(negedge clk); n++; end
    b = txq.size() != 0 ? 64'(txq.pop_front()) : '1;
    chk(tag, b, 64'(exp));
  endtask
  initial begin
    bus.rx_dv = 1'b0;
    bus.rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_inc", bus.phase_inc, INIT);
    chk("rst_step", bus.step_sel, 0);
    chk("rst_txdv", bus.tx_dv, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rel_inc", bus.phase_inc, INIT);
    send(8'h2B);
    chk("up_inc", bus.phase_inc, 64'h104B2C742236B19);
    chk("up_iv", bus.inc_valid, 1);
    @(negedge clk);
    chk("up_iv_end", bus.inc_valid, 0);
    expect_tx("up_ack", 8'h41);
    load(64'h1B1B1B1B1B1B1B1);
    chk("ld_inc", bus.phase_inc, 64'h1B1B1B1B1B1B1B1);
    chk("ld_iv", bus.inc_valid, 1);
    chk("ld_busy", bus.busy, 1);
    expect_tx("ld_ack", 8'h41);
    e0 = err_cnt;
    load(64'h7FFFFFFFFFFFFFFF);
    expect_tx("ldbad_ack", 8'h45);
    chk("ldbad_err", 64'(err_cnt - e0), 1);
    chk("ldbad_inc", bus.phase_inc, 64'h1B1B1B1B1B1B1B1);
    send(8'h50); send(8'h02);
    chk("p2_inc", bus.phase_inc, 64'h28EE0CC5170287A);
    expect_tx("p2_ack", 8'h41);
    e0 = err_cnt;
    send(8'h50); send(8'h07);
    expect_tx("p7_ack", 8'h45);
    chk("p7_err", 64'(err_cnt - e0), 1);
    chk("p7_inc", bus.phase_inc, 64'h28EE0CC5170287A);
    e0 = err_cnt;
    send(8'h46); send(8'h11); send(8'h22); send(8'h33);
    chk("to_busy_on", bus.busy, 1);
    for (int n = 0; n < TO + 20 && bus.busy; n++) @(negedge clk);
    chk("to_busy_off", bus.busy, 0);
    expect_tx("to_ack", 8'h45);
    chk("to_err", 64'(err_cnt - e0), 1);
    chk("to_inc", bus.phase_inc, 64'h28EE0CC5170287A);
    send(8'h2D);
    chk("dn_inc", bus.phase_inc, 64'h28E656FAD1DC198);
    chk("dn_iv", bus.inc_valid, 1);
    expect_tx("dn_ack", 8'h41);
    send(8'h50); send(8'h01);
    expect_tx("p1_ack", 8'h41);
    e0 = err_cnt;
    send(8'h51);
    chk("q_busy", bus.busy, 1);
    repeat (3) @(negedge clk);
    send(8'h2B);
    for (int i = 7; i >= 0; i--) expect_tx($sformatf("q_b%0d", 7 - i), qv[i*8 +: 8]);
    expect_tx("q_ack", 8'h41);
    chk("q_err", 64'(err_cnt - e0), 1);
    chk("q_inc", bus.phase_inc, INIT);
    chk("q_busy_off", bus.busy, 0);
    load(64'h0);
    expect_tx("ld0_ack", 8'h41);
    e0 = iv_cnt;
    send(8'h2D);
    expect_tx("min_ack", 8'h41);
    chk("min_iv", 64'(iv_cnt - e0), 0);
    chk("min_inc", bus.phase_inc, 64'h0);
    send(8'h53);
    chk("s_sel", bus.step_sel, 1);
    expect_tx("s_ack", 8'h41);
    send(8'h2B);
    chk("co_inc", bus.phase_inc, 64'h45641C6E59DF0);
    expect_tx("co_ack", 8'h41);
    load(MAXI);
    expect_tx("ldmax_ack", 8'h41);
    e0 = iv_cnt;
    send(8'h2B);
    expect_tx("max_ack", 8'h41);
    chk("max_iv", 64'(iv_cnt - e0), 0);
    chk("max_inc", bus.phase_inc, MAXI);
    e0 = err_cnt;
    send(8'h5A);
    expect_tx("bad_ack", 8'h45);
    chk("bad_err", 64'(err_cnt - e0), 1);
    chk("bad_inc", bus.phase_inc, MAXI);
    send(8'h46); send(8'h01); send(8'h02);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_inc", bus.phase_inc, INIT);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nco_tune_ctrl.md
Name: nco_tune_ctrl

Overview:
UART-driven tuning controller for the receiver NCO. It parses command bytes from uart_rx and drives the 64-bit phase increment consumed by nco_sig. The phase increment feeds the SinCos LO, then the Mixer and the CIC. Commands cover direct loads, presets and frequency steps, and every command is answered with one ack byte through uart_tx. Tuning formula: inc = 2^64 * Fout / Fclk, with Fclk = 136 MHz.

Parameters:
INIT_INC, 64'h104376A9DD10437, increment after reset (540 kHz)
STEP_FINE, 64'h7B5CA45266E2, 1 kHz step
STEP_COARSE, 64'h45641C6E59DF0, 9 kHz step
PRESET0, 64'h1B1B1B1B1B1B1B1, preset 0 (900 kHz)
PRESET1, 64'h104376A9DD10437, preset 1 (540 kHz)
PRESET2, 64'h28EE0CC5170287A, preset 2 (1359 kHz)
PRESET3, 64'h19C0268CF359C02, preset 3 (855 kHz)
MIN_INC, 64'h0, lowest legal increment
MAX_INC, 64'h3C3C3C3C3C3C3C3, highest legal increment (2 MHz)
TIMEOUT_CLKS, 1360000, idle clocks allowed inside a multi-byte frame (10 ms)

Ports:
clk  in  1  system clock (osc_clk, 136 MHz)
rst_n  in  1  asynchronous reset, active low
rx_dv  in  1  one-cycle strobe, rx_byte is valid
rx_byte  in  8  received byte
tx_active  in  1  uart_tx busy
tx_dv  out  1  one-cycle strobe to uart_tx
tx_byte  out  8  byte to transmit
phase_inc  out  64  NCO phase increment
inc_valid  out  1  one-cycle pulse, asserted in the same cycle phase_inc changes
step_sel  out  1  0 = fine step, 1 = coarse step
busy  out  1  high while a frame is being parsed or a query is being transmitted
err  out  1  one-cycle pulse on any rejected command

Behaviour:
- Async reset values: phase_inc=INIT_INC, step_sel=0, tx_dv=0, tx_byte=0, inc_valid=0, busy=0, err=0, FSM=IDLE, ack slot empty, all counters 0.
- Reset asserted mid-frame or mid-query aborts the operation. No partial update reaches phase_inc.
- Commands, decoded in IDLE on rx_dv:
  - 'F' (0x46): followed by 8 data bytes, MSB first, shifted into a 64-bit staging register. Enter LOAD with byte count 0.
  - 'P' (0x50): followed by 1 index byte. Enter PIDX.
  - '+' (0x2B): phase_inc += current step. Apply in the next cycle.
  - '-' (0x2D): phase_inc -= current step. Apply in the next cycle.
  - 'S' (0x53): toggle step_sel. Ack 'A'.
  - 'Q' (0x51): transmit phase_inc as 8 bytes, MSB first. Enter QUERY.
  - Any other byte: ack 'E', err pulse, no state change.
- LOAD:
  - Counts bytes 0..7. On the 8th rx_dv the FSM enters APPLY.
  - If MIN_INC <= staged value <= MAX_INC: phase_inc=staged and inc_valid=1, both in the cycle after the 8th rx_dv. Ack 'A'.
  - Otherwise: phase_inc unchanged, ack 'E', err pulse.
- PIDX:
  - Index 0..3: load the matching PRESETn with the same latency and inc_valid pulse as LOAD. Ack 'A'.
  - Index >3: ack 'E', err pulse.
- Step arithmetic uses 65-bit intermediates.
  - Up: if phase_inc + step > MAX_INC, phase_inc=MAX_INC.
  - Down: if phase_inc < MIN_INC + step, phase_inc=MIN_INC.
  - inc_valid pulses only if the value actually changed. Ack 'A' either way.
- Timeout:
  - The timeout counter runs in LOAD and PIDX and clears on every rx_dv.
  - When the counter reaches TIMEOUT_CLKS: return to IDLE, discard the staging register, ack 'E', err pulse.
- Ack slot: 1 deep.
  - A queued ack is sent as tx_dv=1 for one cycle with tx_byte=ack, in the first cycle tx_active=0 and no tx_dv was issued in the prior 2 cycles. The 2-cycle guard covers uart_tx latency.
  - A new ack arriving while the slot is full overwrites it. Only the newest ack is sent.
- QUERY:
  - Latch phase_inc at entry, so a concurrent change does not tear the transmitted value.
  - Send 8 bytes using the same tx_dv/tx_active rule, then ack 'A'.
  - rx_dv during QUERY: byte dropped, err pulse.
- busy=1 in LOAD, PIDX, APPLY and QUERY.
- The FSM returns to IDLE in the cycle after APPLY.
- rx_dv in the same cycle as APPLY is impossible, because the UART byte time is much longer than 1 cycle. If it happens anyway, the byte is ignored and err pulses.

Test Plan:
- Reset release -> phase_inc=104376A9DD10437, step_sel=0, no tx_dv.
- '+' -> phase_inc=104B2C742236B19 one cycle after rx_dv, inc_valid=1 for 1 cycle, tx_byte=0x41.
- 'F' then 1B 1B 1B 1B 1B 1B 1B 1B -> phase_inc=1B1B1B1B1B1B1B1 after the 8th byte. 'F' then 7F FF FF FF FF FF FF FF -> ack 0x45, err pulse, phase_inc unchanged.
- 'P' 02 -> phase_inc=28EE0CC5170287A, ack 'A'. 'P' 07 -> ack 'E', no change.
- 'F' plus 3 bytes, then silence for TIMEOUT_CLKS -> ack 'E', busy falls, phase_inc unchanged. A following '-' is accepted normally.
- 'Q' with tx_active modelled at 11550 clks/byte -> 8 bytes 01 04 37 6A 9D D1 04 37 then 0x41. '-' with phase_inc=MIN_INC -> no inc_valid, ack 'A'.
